// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle sequencer: state encoding,
// memory command codes and small state-classification helpers.
package multicycle_ctrl_pkg;

    localparam int W_MEM_CMD = 2;

    localparam logic [W_MEM_CMD-1:0] MEM_NOP   = 2'd0;
    localparam logic [W_MEM_CMD-1:0] MEM_READ  = 2'd1;
    localparam logic [W_MEM_CMD-1:0] MEM_WRITE = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_e;

    // States that count toward cycle_cnt (an instruction is in flight).
    function automatic logic is_active(input state_e s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) ||
               (s == ST_MEM)   || (s == ST_WB);
    endfunction

    // States that hold a request open while waiting for an ack.
    function automatic logic is_wait(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_req_timeout.sv
// Request timeout counter shared by the FETCH and MEM handshakes.
// Held at zero while no request is open, so it starts from zero on every
// entry to a waiting state. expire_o fires combinationally on the waiting
// cycle that would bring the count to TIMEOUT; TIMEOUT = 0 disables it.
module req_timeout #(
    parameter int TIMEOUT = 255,
    parameter int W_TO    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam logic [W_TO-1:0] LIMIT = (TIMEOUT == 0) ? '0 : W_TO'(TIMEOUT - 1);

    logic [W_TO-1:0] cnt_q;

    assign expire_o = (TIMEOUT != 0) && inc_i && (cnt_q == LIMIT);

    // Clear while idle, count each cycle a request waits without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (inc_i && !expire_o) begin
            cnt_q <= cnt_q + W_TO'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: steps each instruction through FETCH, DECODE, EXEC,
// optional MEM and WB, runs the imem/dmem req/ack handshakes and gates the
// PC, IR and register-file writes. Halts on exit syscall, faults on a
// handshake timeout. All outputs are registered Moore outputs except ir_wen,
// which follows imem_ack in the fetch cycle so the IR captures the data beat.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int W_TO    = 8,
    parameter int W_CNT   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic                 imem_req,
    input  logic                 imem_ack,
    output logic                 ir_wen,
    input  logic                 dec_reg_wen,
    input  logic [W_MEM_CMD-1:0] dec_mem_cmd,
    input  logic                 dec_halt,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 pc_wen,
    output logic                 rf_wen,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 fault,
    output logic [W_CNT-1:0]     cycle_cnt,
    output logic [W_CNT-1:0]     instr_cnt
);

    state_e           state_q, state_d;
    logic             imem_req_q, dmem_req_q, dmem_we_q;
    logic             pc_wen_q, rf_wen_q, halted_q, fault_q;
    logic [W_CNT-1:0] cycle_cnt_q, instr_cnt_q;

    logic wait_s;
    logic ack_s;
    logic expire_s;

    // An ack only counts in the state that owns the matching request.
    assign wait_s = is_wait(state_q);
    assign ack_s  = ((state_q == ST_FETCH) && imem_ack) ||
                    ((state_q == ST_MEM)   && dmem_ack);

    req_timeout #(
        .TIMEOUT (TIMEOUT),
        .W_TO    (W_TO)
    ) u_req_timeout (
        .clk      (clk),
        .rst      (rst),
        .load_i   (!wait_s),
        .inc_i    (wait_s && !ack_s),
        .expire_o (expire_s)
    );

    // Next-state selection; an ack on the expiry cycle takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (run)      state_d = ST_FETCH;  else state_d = ST_IDLE;
            ST_FETCH: begin
                if (imem_ack)        state_d = ST_DECODE;
                else if (expire_s)   state_d = ST_FAULT;
                else                 state_d = ST_FETCH;
            end
            ST_DECODE: if (dec_halt) state_d = ST_HALT;   else state_d = ST_EXEC;
            ST_EXEC: begin
                if (dec_mem_cmd != MEM_NOP) state_d = ST_MEM;
                else                        state_d = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack)        state_d = ST_WB;
                else if (expire_s)   state_d = ST_FAULT;
                else                 state_d = ST_MEM;
            end
            ST_WB:     if (run)      state_d = ST_FETCH;  else state_d = ST_IDLE;
            ST_HALT:                 state_d = ST_HALT;
            ST_FAULT:                state_d = ST_FAULT;
            default:                 state_d = ST_FAULT;
        endcase
    end

    // State register, Moore outputs decoded from the next state, and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            pc_wen_q    <= 1'b0;
            rf_wen_q    <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= (state_d == ST_FETCH);
            dmem_req_q  <= (state_d == ST_MEM);
            dmem_we_q   <= (state_d == ST_MEM) && (dec_mem_cmd == MEM_WRITE);
            pc_wen_q    <= (state_d == ST_WB);
            rf_wen_q    <= (state_d == ST_WB) && dec_reg_wen;
            halted_q    <= (state_d == ST_HALT);
            fault_q     <= (state_d == ST_FAULT);
            cycle_cnt_q <= is_active(state_q) ? cycle_cnt_q + W_CNT'(1) : cycle_cnt_q;
            instr_cnt_q <= (state_q == ST_WB) ? instr_cnt_q + W_CNT'(1) : instr_cnt_q;
        end
    end

    assign imem_req  = imem_req_q;
    assign ir_wen    = imem_req_q && imem_ack;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign pc_wen    = pc_wen_q;
    assign rf_wen    = rf_wen_q;
    assign state     = state_q;
    assign halted    = halted_q;
    assign fault     = fault_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Each stimulus step drives one cycle of
// inputs and queues the expected state/outputs/counters for that cycle; a
// monitor on the falling edge pops and compares.
module tb_multicycle_ctrl;

    localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_E = 3'd3,
                           S_M = 3'd4, S_W = 3'd5, S_H = 3'd6, S_X = 3'd7;
    // Output vector: {imem_req, ir_wen, dmem_req, dmem_we, pc_wen, rf_wen, halted, fault}
    localparam logic [7:0] O_NONE = 8'b0000_0000, O_F   = 8'b1000_0000,
                           O_FACK = 8'b1100_0000, O_MR  = 8'b0010_0000,
                           O_MW   = 8'b0011_0000, O_WBR = 8'b0000_1100,
                           O_WB   = 8'b0000_1000, O_H   = 8'b0000_0010,
                           O_X    = 8'b0000_0001;
    localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2;

    logic        clk = 1'b0;
    logic        rst, run, imem_ack, dmem_ack, dec_reg_wen, dec_halt;
    logic [1:0]  dec_mem_cmd;
    logic        imem_req, ir_wen, dmem_req, dmem_we, pc_wen, rf_wen, halted, fault;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instr_cnt;
    logic [7:0]  obs_outs;

    typedef struct {
        logic [2:0]  st;
        logic [7:0]  outs;
        logic [31:0] cyc;
        logic [31:0] ins;
        int          tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   tag_cnt  = 0;
    int   m_cyc    = 0;
    int   m_ins    = 0;
    logic done     = 1'b0;
    logic final_done = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(4), .W_TO(8), .W_CNT(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .ir_wen      (ir_wen),
        .dec_reg_wen (dec_reg_wen),
        .dec_mem_cmd (dec_mem_cmd),
        .dec_halt    (dec_halt),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .pc_wen      (pc_wen),
        .rf_wen      (rf_wen),
        .state       (state),
        .halted      (halted),
        .fault       (fault),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    assign obs_outs = {imem_req, ir_wen, dmem_req, dmem_we, pc_wen, rf_wen, halted, fault};

    // Monitor: compare one queued expectation per cycle, then check the queue drained.
    always @(negedge clk) begin
        if (done && !final_done) begin
            final_done = 1'b1;
            n_assert++;
            if (sb_q.size() != 0) begin
                n_fail++;
                $display("FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());
            end
        end else if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_assert++;
            if (state !== mon_e.st || obs_outs !== mon_e.outs ||
                cycle_cnt !== mon_e.cyc || instr_cnt !== mon_e.ins) begin
                n_fail++;
                $display("FAIL step%0d: got st=%0d outs=%b cyc=%0d ins=%0d, want st=%0d outs=%b cyc=%0d ins=%0d",
                         mon_e.tag, state, obs_outs, cycle_cnt, instr_cnt,
                         mon_e.st, mon_e.outs, mon_e.cyc, mon_e.ins);
            end
        end
    end

    // One cycle: drive inputs, queue what the DUT must show during this cycle.
    task automatic step(input logic r, input logic ru, input logic ia, input logic da,
                        input logic dh, input logic rw, input logic [1:0] mc,
                        input logic [2:0] est, input logic [7:0] eo);
        exp_t e;
        rst = r; run = ru; imem_ack = ia; dmem_ack = da;
        dec_halt = dh; dec_reg_wen = rw; dec_mem_cmd = mc;
        e.st = est; e.outs = eo; e.cyc = m_cyc; e.ins = m_ins; e.tag = tag_cnt;
        sb_q.push_back(e);
        tag_cnt++;
        if (r) begin
            m_cyc = 0;
            m_ins = 0;
        end else begin
            if (est == S_F || est == S_D || est == S_E || est == S_M || est == S_W) m_cyc++;
            if (est == S_W) m_ins++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        dec_halt = 1'b0; dec_reg_wen = 1'b0; dec_mem_cmd = NOP;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_cyc = 0;
        m_ins = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: ADD, zero-wait acks; ack in IDLE ignored; run dropped in DECODE
        do_reset();
        step(0,0,1,1,0,1,NOP, S_I, O_NONE);
        step(0,1,1,1,0,1,NOP, S_I, O_NONE);
        step(0,1,1,1,0,1,NOP, S_F, O_FACK);
        step(0,0,1,1,0,1,NOP, S_D, O_NONE);
        step(0,0,1,1,0,1,NOP, S_E, O_NONE);
        step(0,0,1,1,0,1,NOP, S_W, O_WBR);
        step(0,0,0,0,0,0,NOP, S_I, O_NONE);

        // 2: LW with dmem_ack three cycles late
        do_reset();
        step(0,1,1,0,0,1,RD, S_I, O_NONE);
        step(0,1,1,0,0,1,RD, S_F, O_FACK);
        step(0,1,0,0,0,1,RD, S_D, O_NONE);
        step(0,1,0,0,0,1,RD, S_E, O_NONE);
        step(0,1,0,0,0,1,RD, S_M, O_MR);
        step(0,1,0,0,0,1,RD, S_M, O_MR);
        step(0,1,0,0,0,1,RD, S_M, O_MR);
        step(0,1,0,1,0,1,RD, S_M, O_MR);
        step(0,0,0,0,0,1,RD, S_W, O_WBR);
        step(0,0,0,0,0,0,NOP, S_I, O_NONE);

        // 3: SW, then back-to-back NOP with one fetch wait cycle
        do_reset();
        step(0,1,1,1,0,0,WR, S_I, O_NONE);
        step(0,1,1,1,0,0,WR, S_F, O_FACK);
        step(0,1,0,0,0,0,WR, S_D, O_NONE);
        step(0,1,0,0,0,0,WR, S_E, O_NONE);
        step(0,1,0,1,0,0,WR, S_M, O_MW);
        step(0,1,0,0,0,0,WR, S_W, O_WB);
        step(0,1,0,0,0,0,NOP, S_F, O_F);
        step(0,1,1,0,0,0,NOP, S_F, O_FACK);
        step(0,1,0,0,0,0,NOP, S_D, O_NONE);
        step(0,0,0,0,0,0,NOP, S_E, O_NONE);
        step(0,0,0,0,0,0,NOP, S_W, O_WB);
        step(0,0,0,0,0,0,NOP, S_I, O_NONE);

        // 4: exit syscall -> HALT, run and acks ignored, rst leaves
        do_reset();
        step(0,1,1,1,1,1,NOP, S_I, O_NONE);
        step(0,1,1,1,1,1,NOP, S_F, O_FACK);
        step(0,1,0,0,1,1,NOP, S_D, O_NONE);
        step(0,0,0,0,0,1,NOP, S_H, O_H);
        step(0,1,1,1,0,1,NOP, S_H, O_H);
        step(0,0,1,1,0,1,NOP, S_H, O_H);
        step(1,0,0,0,0,0,NOP, S_H, O_H);
        step(0,0,0,0,0,0,NOP, S_I, O_NONE);

        // 5a: fetch never acked -> FAULT after 4 waiting cycles, absorbing
        do_reset();
        step(0,1,0,0,0,0,NOP, S_I, O_NONE);
        step(0,1,0,0,0,0,NOP, S_F, O_F);
        step(0,1,0,0,0,0,NOP, S_F, O_F);
        step(0,1,0,0,0,0,NOP, S_F, O_F);
        step(0,1,0,0,0,0,NOP, S_F, O_F);
        step(0,1,1,1,0,0,NOP, S_X, O_X);
        step(0,1,1,1,0,0,NOP, S_X, O_X);

        // 5b: ack on the expiry cycle wins
        do_reset();
        step(0,1,0,0,0,1,NOP, S_I, O_NONE);
        step(0,1,0,0,0,1,NOP, S_F, O_F);
        step(0,1,0,0,0,1,NOP, S_F, O_F);
        step(0,1,0,0,0,1,NOP, S_F, O_F);
        step(0,1,1,0,0,1,NOP, S_F, O_FACK);
        step(0,1,0,0,0,1,NOP, S_D, O_NONE);
        step(0,0,0,0,0,1,NOP, S_E, O_NONE);
        step(0,0,0,0,0,1,NOP, S_W, O_WBR);
        step(0,0,0,0,0,0,NOP, S_I, O_NONE);

        // 6: rst while dmem_req is open; late ack ignored
        do_reset();
        step(0,1,1,0,0,1,RD, S_I, O_NONE);
        step(0,1,1,0,0,1,RD, S_F, O_FACK);
        step(0,1,0,0,0,1,RD, S_D, O_NONE);
        step(0,1,0,0,0,1,RD, S_E, O_NONE);
        step(0,1,0,0,0,1,RD, S_M, O_MR);
        step(1,0,0,0,0,1,RD, S_M, O_MR);
        step(0,0,0,1,0,1,RD, S_I, O_NONE);
        step(0,0,0,0,0,1,RD, S_I, O_NONE);
        step(0,0,0,0,0,0,NOP, S_I, O_NONE);

        done = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
